frame_disassembler: RTL

- Receive-side counterpart of the TX frame assembler.
- Consumes the demodulated byte stream, which is aligned by an external time synchronizer strobe `sof`.
- Discards the time-sync part of the 480-sample preamble and captures its last 128 samples as the channel-estimation sequence.
- Captures the following 512 data samples (8 symbols × 64-point FFT) and presents both buffers to the downstream FFT/equalizer through a random-access read port, with a ready/done handshake.

---
 rtl/vlc_frame_pkg.sv | 33 +++
 rtl/frame_disassembler_frame_ram.sv | 39 +++
 rtl/frame_disassembler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/vlc_frame_pkg.sv
// Frame geometry and capture-state encoding shared by the TX assembler and RX disassembler.
package vlc_frame_pkg;

    localparam int FFT_POINT  = 64;
    localparam int SYMBOL_NUM = 8;
    localparam int SYNC_LEN   = 480;
    localparam int CHEST_LEN  = 128;
    localparam int DATA_LEN   = FFT_POINT * SYMBOL_NUM;
    localparam int SKIP_LEN   = SYNC_LEN - CHEST_LEN;
    localparam int DW         = 8;
    localparam int CNT_W      = 10;

    // Terminal count values for each capture phase (counter holds index of the sample being taken)
    localparam logic [CNT_W-1:0] SKIP_LAST   = CNT_W'(SKIP_LEN - 1);
    localparam logic [CNT_W-1:0] CHEST_LAST  = CNT_W'(CHEST_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST   = CNT_W'(DATA_LEN - 1);
    localparam logic [CNT_W-1:0] CHEST_DEPTH = CNT_W'(CHEST_LEN);
    localparam logic [CNT_W-1:0] DATA_DEPTH  = CNT_W'(DATA_LEN);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SKIP_SYNC = 3'd1,
        CAP_CHEST = 3'd2,
        CAP_DATA  = 3'd3,
        FULL      = 3'd4
    } frame_state_t;

    function automatic logic addr_in_range(input logic [CNT_W-1:0] addr,
                                           input logic [CNT_W-1:0] depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/frame_disassembler_frame_ram.sv
// Simple dual-port RAM: synchronous write, registered read with enable and clear-to-zero.
module frame_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             rd_clr,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Storage array write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register: loads on enable (zero when clr), otherwise holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= rd_clr ? '0 : mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/frame_disassembler.sv
// RX frame disassembler: drops the time-sync preamble, captures the channel-estimation
// sequence and the data symbols, then serves both buffers through a read port.
module frame_disassembler
    import vlc_frame_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    input  logic          sof,
    input  logic          rx_done,
    input  logic [9:0]    read_ptr,
    input  logic          read_sel,
    output logic [DW-1:0] dout,
    output logic          frame_ready,
    output logic          busy,
    output logic          overrun,
    output logic [15:0]   frame_cnt
);

    frame_state_t     state_r;
    frame_state_t     state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             chest_we_s;
    logic             data_we_s;
    logic             overrun_set_s;
    logic             frame_ready_r;
    logic             busy_r;
    logic             overrun_r;
    logic [15:0]      frame_cnt_r;
    logic             rd_sel_r;
    logic             data_rd_en_s;
    logic             data_rd_clr_s;
    logic             chest_rd_en_s;
    logic             chest_rd_clr_s;
    logic [DW-1:0]    data_rdata_s;
    logic [DW-1:0]    chest_rdata_s;

    // Next-state, counter and buffer write-enable decode; rx_done always takes priority
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        chest_we_s   = 1'b0;
        data_we_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (sof && din_valid && !rx_done) begin
                    state_next_s = SKIP_SYNC;
                    cnt_next_s   = 10'd1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SKIP_SYNC: begin
                if (rx_done) begin
                    state_next_s = IDLE;
                    cnt_next_s   = 10'd0;
                end else if (din_valid) begin
                    if (cnt_r == SKIP_LAST) begin
                        state_next_s = CAP_CHEST;
                        cnt_next_s   = 10'd0;
                    end else begin
                        cnt_next_s = cnt_r + 10'd1;
                    end
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            CAP_CHEST: begin
                if (rx_done) begin
                    state_next_s = IDLE;
                    cnt_next_s   = 10'd0;
                end else if (din_valid) begin
                    chest_we_s = 1'b1;
                    if (cnt_r == CHEST_LAST) begin
                        state_next_s = CAP_DATA;
                        cnt_next_s   = 10'd0;
                    end else begin
                        cnt_next_s = cnt_r + 10'd1;
                    end
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            CAP_DATA: begin
                if (rx_done) begin
                    state_next_s = IDLE;
                    cnt_next_s   = 10'd0;
                end else if (din_valid) begin
                    data_we_s = 1'b1;
                    if (cnt_r == DATA_LAST) begin
                        state_next_s = FULL;
                        cnt_next_s   = 10'd0;
                    end else begin
                        cnt_next_s = cnt_r + 10'd1;
                    end
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            FULL: begin
                if (rx_done) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = FULL;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 10'd0;
            end
        endcase
    end

    assign overrun_set_s = sof && din_valid && !rx_done && (state_r != IDLE);

    // State, counter and status registers; flags are derived from the next state so they
    // line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= 10'd0;
            frame_ready_r <= 1'b0;
            busy_r        <= 1'b0;
            overrun_r     <= 1'b0;
            frame_cnt_r   <= 16'd0;
        end else begin
            state_r       <= state_next_s;
            cnt_r         <= cnt_next_s;
            frame_ready_r <= (state_next_s == FULL);
            busy_r        <= (state_next_s == SKIP_SYNC) || (state_next_s == CAP_CHEST) ||
                             (state_next_s == CAP_DATA);
            if (rx_done) begin
                overrun_r <= 1'b0;
            end else if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end
            if ((state_next_s == FULL) && (state_r != FULL)) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
        end
    end

    // Only the selected buffer's read register loads, so the unselected one never matters
    assign data_rd_en_s   = frame_ready_r && !read_sel;
    assign data_rd_clr_s  = !addr_in_range(read_ptr, DATA_DEPTH);
    assign chest_rd_en_s  = frame_ready_r && read_sel;
    assign chest_rd_clr_s = !addr_in_range(read_ptr, CHEST_DEPTH);

    // Remembers which buffer fed the last read so dout holds while frame_ready is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel_r <= 1'b0;
        end else if (frame_ready_r) begin
            rd_sel_r <= read_sel;
        end
    end

    frame_ram #(
        .DEPTH (DATA_LEN),
        .WIDTH (DW)
    ) u_data_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (data_we_s),
        .wr_addr (cnt_r[8:0]),
        .wr_data (din),
        .rd_en   (data_rd_en_s),
        .rd_clr  (data_rd_clr_s),
        .rd_addr (read_ptr[8:0]),
        .rd_data (data_rdata_s)
    );

    frame_ram #(
        .DEPTH (CHEST_LEN),
        .WIDTH (DW)
    ) u_chest_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (chest_we_s),
        .wr_addr (cnt_r[6:0]),
        .wr_data (din),
        .rd_en   (chest_rd_en_s),
        .rd_clr  (chest_rd_clr_s),
        .rd_addr (read_ptr[6:0]),
        .rd_data (chest_rdata_s)
    );

    assign dout        = rd_sel_r ? chest_rdata_s : data_rdata_s;
    assign frame_ready = frame_ready_r;
    assign busy        = busy_r;
    assign overrun     = overrun_r;
    assign frame_cnt   = frame_cnt_r;

endmodule
